// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

  localparam int OVERSAMPLE = 16;

  // Clocks per oversampling tick, truncated and never below 1.
  function automatic int tick_div(input int freq, input int baud);
    int d;
    d = freq / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversampling tick divider: down-counter with terminal-count tick and synchronous clear.
module uart_rx_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Clear parks the counter at terminal count so the first tick follows clear release directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (cnt == '0)
      cnt <= RELOAD;
    else
      cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0) && !clr;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling, mid-bit sampling and framing-error detection.
//   state | meaning
//   IDLE  | line idle, tick divider held clear, waiting for falling edge
//   START | confirming start bit at its center (glitch filter)
//   DATA  | sampling data bits at bit centers, LSB first
//   STOP  | sampling stop bit; high delivers the word, low flags framing error
//   BREAK | line held low after framing error, waiting for it to return high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int FREQUENCY   = 50000000,
  parameter int BAUDRATE    = 110
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Rx_in,
  output logic [WORD_LENGHT-1:0] Rx_out,
  output logic                   new_Rx,
  output logic                   frame_error,
  output logic                   busy
);

  localparam int TICK_DIV = tick_div(FREQUENCY, BAUDRATE);
  localparam int BW = (WORD_LENGHT > 1) ? $clog2(WORD_LENGHT) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LENGHT - 1);
  localparam logic [3:0] MID_START = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] MID_BIT   = 4'(OVERSAMPLE - 1);

  rx_state_e              state;
  logic                   rx_m, rx_s;
  logic                   tick;
  logic [3:0]             s_cnt;
  logic [BW-1:0]          b_cnt;
  logic [WORD_LENGHT-1:0] shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= Rx_in;
      rx_s <= rx_m;
    end
  end

  // Holding the divider clear while idle aligns tick phase to the start edge.
  uart_rx_tick #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s_cnt       <= '0;
      b_cnt       <= '0;
      shift       <= '0;
      Rx_out      <= '0;
      new_Rx      <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      new_Rx      <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == MID_START) begin
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
                s_cnt <= '0;
                b_cnt <= '0;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == MID_BIT) begin
              shift <= {rx_s, shift[WORD_LENGHT-1:1]};
              if (b_cnt == LAST_BIT)
                state <= STOP;
              else
                b_cnt <= b_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            s_cnt <= s_cnt + 4'd1;
            // Leaving at mid stop bit lets a following start edge be caught with no idle gap.
            if (s_cnt == MID_BIT) begin
              if (rx_s) begin
                Rx_out <= shift;
                new_Rx <= 1'b1;
                state  <= IDLE;
                busy   <= 1'b0;
              end else begin
                frame_error <= 1'b1;
                state       <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
